// File: rtl/inta_cascade_sequencer.sv
// -----------------------------------------------------------------------------
// inta_cascade_sequencer
//
// Acknowledge-cycle sequencer for an 8259-style PIC. Tracks the two-pulse CPU
// INTA handshake, drives the cascade bus when acting as master (or samples it
// when acting as slave), and places the interrupt vector on the data bus
// during the second pulse when this device owns the cycle.
//
// Optional feature macro: AUTO_EOI_EN
//   defined   -> aeoi_clr pulses lvl on the ACK2->IDLE transition
//   undefined -> aeoi_clr is tied to zero (port still present)
//
// Parameters
//   GAP_TIMEOUT  max cycles INTA_n may stay high between the two pulses
//   CNT_W        gap counter width, 2**CNT_W > GAP_TIMEOUT
//
// Ports
//   clk              in   system clock
//   rst_n            in   synchronous active-low reset
//   INTA_n           in   CPU acknowledge, active low, synchronous to clk
//   SP_EN            in   1 = master, 0 = slave
//   icw3             in   master: slave-present mask; slave: [2:0] own ID
//   icw2             in   vector base, [7:3] used
//   isr_highest_bit  in   one-hot highest pending level (0 = none)
//   CAS_in           in   sampled cascade bus
//   CAS_out          out  cascade ID driven as master
//   CAS_oe           out  cascade bus output enable
//   D_out            out  vector byte (0 when D_oe is low)
//   D_oe             out  data bus output enable
//   isr_set          out  one-cycle pulse: ISR bit to set
//   ack_err          out  one-cycle pulse: gap timeout abort
//   aeoi_clr         out  one-cycle pulse: ISR bit to clear (auto EOI)
// -----------------------------------------------------------------------------
module inta_cascade_sequencer #(
  parameter int GAP_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INTA_n,
  input  logic       SP_EN,
  input  logic [7:0] icw3,
  input  logic [7:0] icw2,
  input  logic [7:0] isr_highest_bit,
  input  logic [2:0] CAS_in,
  output logic [2:0] CAS_out,
  output logic       CAS_oe,
  output logic [7:0] D_out,
  output logic       D_oe,
  output logic [7:0] isr_set,
  output logic       ack_err,
  output logic [7:0] aeoi_clr
);

  typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

  state_t state_reg, state_next;

  logic             inta_reg;
  logic             fall, rise;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       lvl_reg;
  logic [4:0]       vec_base_reg;
  logic [2:0]       own_id_reg;
  logic             master_reg;
  logic             cas_drive_reg;
  logic             sel_reg;
  logic             ack1_new_reg;
  logic [2:0]       lvl_idx;

  logic [7:0]       lvl_new;
  logic             slave_hit;
  logic             enter_ack1, ack1_to_gap, gap_expired, ack2_exit;

  logic [7:0]       isr_set_reg, isr_set_next;
  logic             ack_err_reg, ack_err_next;
  logic             cas_oe_reg, cas_oe_next;
  logic [2:0]       cas_out_reg, cas_out_next;
  logic             d_oe_reg, d_oe_next;
  logic [7:0]       d_out_reg, d_out_next;

  // Only the upper five vector bits come from icw2.
  logic unused_icw2_bits;
  assign unused_icw2_bits = ^icw2[2:0];

  assign fall = inta_reg & ~INTA_n;
  assign rise = ~inta_reg & INTA_n;

  // No pending level at the first pulse is answered as a spurious IR7.
  assign lvl_new   = (isr_highest_bit == 8'h00) ? 8'h80 : isr_highest_bit;
  assign slave_hit = SP_EN & (|(icw3 & lvl_new));

  assign enter_ack1  = (state_reg == IDLE) && fall;
  assign ack1_to_gap = (state_reg == ACK1) && rise;
  assign gap_expired = (state_reg == GAP) && !fall &&
                       (cnt_reg == CNT_W'(GAP_TIMEOUT - 1));
  assign ack2_exit   = (state_reg == ACK2) && rise;

  // Binary index of the one-hot level: bit b of the index is the OR of the
  // level bits whose position has bit b set.
  localparam logic [23:0] IDX_MASKS = {8'hF0, 8'hCC, 8'hAA};
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_idx
      assign lvl_idx[gi] = |(lvl_reg & IDX_MASKS[gi*8 +: 8]);
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; impossible edges (fall in ACK1/ACK2, rise in GAP)
  // simply hold the state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (fall) state_next = ACK1;
      ACK1: if (rise) state_next = GAP;
      GAP: begin
        if (fall)             state_next = ACK2;
        else if (gap_expired) state_next = IDLE;
      end
      ACK2: if (rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cycle context: everything is frozen at ACK1 entry so later changes of
  // SP_EN, icw2/icw3 or the resolver output cannot disturb a running cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inta_reg      <= 1'b1;
      cnt_reg       <= '0;
      lvl_reg       <= '0;
      vec_base_reg  <= '0;
      own_id_reg    <= '0;
      master_reg    <= 1'b0;
      cas_drive_reg <= 1'b0;
      sel_reg       <= 1'b0;
      ack1_new_reg  <= 1'b0;
    end else begin
      inta_reg     <= INTA_n;
      ack1_new_reg <= enter_ack1;
      if (enter_ack1) begin
        lvl_reg       <= lvl_new;
        vec_base_reg  <= icw2[7:3];
        own_id_reg    <= icw3[2:0];
        master_reg    <= SP_EN;
        cas_drive_reg <= slave_hit;
        // Master owns the vector unless the level belongs to a slave;
        // a slave decides later from the cascade bus.
        sel_reg       <= SP_EN & ~slave_hit;
      end
      if (ack1_to_gap) begin
        cnt_reg <= '0;
        // The master has driven CAS for the whole first pulse by now.
        if (!master_reg) sel_reg <= (CAS_in == own_id_reg);
      end else if (state_reg == GAP && !fall) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    isr_set_next = ack1_new_reg ? lvl_reg : 8'h00;
    ack_err_next = gap_expired;
    cas_oe_next  = (state_reg != IDLE) && cas_drive_reg;
    cas_out_next = cas_oe_next ? lvl_idx : 3'b000;
    d_oe_next    = (state_reg == ACK2) && sel_reg;
    d_out_next   = d_oe_next ? {vec_base_reg, lvl_idx} : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isr_set_reg <= '0;
      ack_err_reg <= 1'b0;
      cas_oe_reg  <= 1'b0;
      cas_out_reg <= '0;
      d_oe_reg    <= 1'b0;
      d_out_reg   <= '0;
    end else begin
      isr_set_reg <= isr_set_next;
      ack_err_reg <= ack_err_next;
      cas_oe_reg  <= cas_oe_next;
      cas_out_reg <= cas_out_next;
      d_oe_reg    <= d_oe_next;
      d_out_reg   <= d_out_next;
    end
  end

  assign isr_set = isr_set_reg;
  assign ack_err = ack_err_reg;
  assign CAS_oe  = cas_oe_reg;
  assign CAS_out = cas_out_reg;
  assign D_oe    = d_oe_reg;
  assign D_out   = d_out_reg;

`ifdef AUTO_EOI_EN
  logic [7:0] aeoi_clr_reg;
  // Automatic EOI only on a completed cycle, never on abort.
  always_ff @(posedge clk) begin
    if (!rst_n) aeoi_clr_reg <= '0;
    else        aeoi_clr_reg <= ack2_exit ? lvl_reg : 8'h00;
  end
  assign aeoi_clr = aeoi_clr_reg;
`else
  logic unused_ack2_exit;
  assign unused_ack2_exit = ack2_exit;
  assign aeoi_clr = 8'h00;
`endif

endmodule
